// File: rtl/ysyx_22050598_ifid_buf_if.sv
// Fetch/decode bundle around the IF/ID instruction buffer.
//   fetch side : ifu_stall, pc_now, if_inst, flush_pc_en -> buffer
//                pc_stall, prdt_pc_en, prdt_pc_add_op    <- buffer
//   decode side: id_ready                                 -> buffer
//                id_valid, id_pc, id_inst, id_prdt_taken  <- buffer
// slave  : the buffer itself.
// master : the surrounding pipeline (or a bench) driving the buffer.
interface ysyx_22050598_ifid_buf_if;
  logic        ifu_stall;
  logic [63:0] pc_now;
  logic [31:0] if_inst;
  logic        flush_pc_en;
  logic        pc_stall;
  logic        prdt_pc_en;
  logic [63:0] prdt_pc_add_op;
  logic        id_ready;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_prdt_taken;

  modport slave (
    input  ifu_stall, pc_now, if_inst, flush_pc_en, id_ready,
    output pc_stall, prdt_pc_en, prdt_pc_add_op,
           id_valid, id_pc, id_inst, id_prdt_taken
  );

  modport master (
    output ifu_stall, pc_now, if_inst, flush_pc_en, id_ready,
    input  pc_stall, prdt_pc_en, prdt_pc_add_op,
           id_valid, id_pc, id_inst, id_prdt_taken
  );
endinterface

// File: rtl/ysyx_22050598_ifid_buf.sv
// IF/ID instruction buffer with static branch predecode.
// Captures {pc, inst, taken} from fetch into a DEPTH-entry FIFO and presents
// the head entry to decode. JAL and backward conditional branches are
// predicted taken on the incoming word; the offset goes back to fetch in the
// same cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - fetch/decode bundle (slave side), see ysyx_22050598_ifid_buf_if
module ysyx_22050598_ifid_buf #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22050598_ifid_buf_if.slave    bus
);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        taken;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [6:0]     OP_JAL   = 7'b1101111;
  localparam logic [6:0]     OP_BR    = 7'b1100011;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic        full, push, pop;
  logic        is_jal, is_bbr, taken;
  logic [63:0] imm_j, imm_b;
  logic [31:0] inst;
  entry_t      head;

  // Handshake terms. No push while full even if the head pops this cycle:
  // there is no bypass, so the slot only frees up at the edge.
  assign full     = (cnt_q == FULL_CNT);
  assign push     = ~bus.ifu_stall & ~full & ~bus.flush_pc_en;
  assign pop      = bus.id_valid & bus.id_ready & ~bus.flush_pc_en;
  assign bus.pc_stall = ~bus.flush_pc_en & (bus.ifu_stall | full);

  // Static predecode: JAL always taken, conditional branch taken when the
  // offset is negative (backward-taken, forward-not-taken).
  assign inst   = bus.if_inst;
  assign is_jal = (inst[6:0] == OP_JAL);
  assign is_bbr = (inst[6:0] == OP_BR) & inst[31];
  assign taken  = is_jal | is_bbr;
  assign imm_j  = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b  = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  assign bus.prdt_pc_en     = push & taken;
  assign bus.prdt_pc_add_op = is_jal ? imm_j : (is_bbr ? imm_b : 64'd0);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.flush_pc_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push & ~pop)      cnt_d = cnt_q + 1'b1;
      else if (pop & ~push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; a flush leaves the data in place, the output gating
  // below hides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{pc: bus.pc_now, inst: bus.if_inst, taken: taken};
    end
  end

  assign head              = mem_q[rd_ptr_q];
  assign bus.id_valid      = (cnt_q != '0);
  assign bus.id_pc         = bus.id_valid ? head.pc    : 64'd0;
  assign bus.id_inst       = bus.id_valid ? head.inst  : 32'd0;
  assign bus.id_prdt_taken = bus.id_valid & head.taken;

endmodule
